data_sync_mc: RTL and testbench
===============================

DATA_SYNC_MC -- requirements
Module: data_sync_mc

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, the synchroniser depth per enable line; legal range 2 to 4.
REQ-002 SHALL have parameter BUS_WIDTH, default 8, the data width per channel.
REQ-003 SHALL have parameter NUM_CH, default 2, the number of independent channels.
REQ-004 SHALL have parameter TOGGLE_MODE, default 0; 0 = level mode, capture on rising edge of enable; 1 = toggle mode, capture on either edge of enable.
REQ-005 SHALL have port CLK  input  1  destination-domain clock; all state on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Unsync_bus  input  NUM_CH*BUS_WIDTH  source-domain data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
REQ-008 SHALL have port bus_enable  input  NUM_CH  source-domain qualifier; bit c belongs to channel c.
REQ-009 SHALL have port sync_ready  input  NUM_CH  downstream accepts channel c data when high.
REQ-010 SHALL have port overrun_clr  input  1  synchronous clear of all overrun flags.
REQ-011 SHALL have port sync_bus  output  NUM_CH*BUS_WIDTH  registered captured data, with the same packing as Unsync_bus.
REQ-012 SHALL have port sync_valid  output  NUM_CH  channel c holds unconsumed data.
REQ-013 SHALL have port enable_pulse  output  NUM_CH  one-cycle registered strobe per capture.
REQ-014 SHALL have port overrun  output  NUM_CH  sticky flag: unconsumed data was overwritten.

Function
REQ-015 Each channel SHALL be fully independent; no cross-channel logic except the shared overrun_clr.
REQ-016 Synchroniser chain: bus_enable[c] SHALL pass through NUM_STAGES flops; sen = last stage; sprev = sen delayed one CLK.
REQ-017 Event detection: evt = sen & ~sprev when TOGGLE_MODE=0; evt = sen ^ sprev when TOGGLE_MODE=1.
REQ-018 Latency: bus_enable transition sampled at edge 1 -> sync_bus, sync_valid and enable_pulse updated at edge NUM_STAGES+1.
REQ-019 On evt, the next edge SHALL load the channel's Unsync_bus slice into sync_bus; otherwise sync_bus SHALL hold.
REQ-020 Capture timing: Unsync_bus is sampled directly only on the evt cycle; the source holds data stable from before its enable transition until after its acknowledgement.
REQ-021 On evt, the next edge SHALL drive enable_pulse high for exactly one cycle; a held-high level in mode 0 SHALL produce one pulse only.
REQ-022 sync_valid SHALL be set at the next edge on evt.
REQ-023 sync_valid SHALL be cleared at the next edge on sync_valid & sync_ready & ~evt.
REQ-024 Otherwise sync_valid SHALL hold.
REQ-025 Simultaneous evt and accept (sync_valid & sync_ready): new data loaded, sync_valid stays 1, overrun unchanged.
REQ-026 evt while sync_valid=1 and sync_ready=0: data SHALL be overwritten (latest wins), sync_valid stays 1, overrun[c] set.
REQ-027 overrun SHALL be cleared at the next edge when overrun_clr=1.
REQ-028 If set and clear of overrun occur in the same cycle, set SHALL win.
REQ-029 sync_ready SHALL be ignored when sync_valid=0.
REQ-030 Back-to-back events SHALL be separated by at least two CLK cycles, the minimum enable pulse width; each event SHALL produce its own capture.

Reset
REQ-031 On RST low, asynchronously: all synchroniser flops, sprev, sync_bus, sync_valid, enable_pulse and overrun SHALL go to 0.
REQ-032 Reset mid-transfer SHALL discard in-flight events. After release, a channel whose enable is already high SHALL capture (mode 0) if sen rises from 0; in mode 1 the first sampled level 1 counts as a toggle.
REQ-033 No output SHALL change in the first NUM_STAGES edges after reset release.

Verification
REQ-034 NUM_STAGES=2, mode 0: ch0 bus=0xA5, enable rises before edge 1 -> at edge 3, sync_bus[7:0]=0xA5, sync_valid[0]=1, enable_pulse[0]=1 for one cycle; ch1 stays 0.
REQ-035 Mode 0, enable held high for 10 cycles, ready=1 -> exactly one enable_pulse; sync_valid clears one cycle after it sets.
REQ-036 Mode 1: enable toggles 0->1->0 with 4-cycle spacing, data 0x11 then 0x22 -> two pulses; sync_bus reads 0x11 then 0x22.
REQ-037 ready=0, two events (0x33, 0x44) -> sync_bus=0x44, sync_valid=1, overrun=1; overrun_clr pulse -> overrun=0.
REQ-038 Event and accept in the same cycle -> sync_valid stays 1 with the new data, overrun=0.
REQ-039 RST asserted one cycle after an enable rise -> all outputs 0 immediately; no pulse after release while enable is low.

Source files
------------

// File: rtl/data_sync_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_sync_mc
// Purpose  : Multi-channel bus synchroniser. Each channel carries its enable
//            qualifier through a NUM_STAGES flop chain into the CLK domain.
//            On a detected enable event, it captures that channel's data slice
//            and raises a one-cycle strobe. A valid/ready handshake holds the
//            captured word until it is consumed, and a sticky overrun flag
//            records any word that was overwritten before it was consumed.
// Ports    :
//   CLK          in   1                  destination clock (rising edge)
//   RST          in   1                  asynchronous active-low reset
//   Unsync_bus   in   NUM_CH*BUS_WIDTH   source data, channel c at
//                                        [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable   in   NUM_CH             source qualifier per channel
//   sync_ready   in   NUM_CH             downstream accepts channel data
//   overrun_clr  in   1                  clears every overrun flag
//   sync_bus     out  NUM_CH*BUS_WIDTH   captured data, same packing
//   sync_valid   out  NUM_CH             channel holds unconsumed data
//   enable_pulse out  NUM_CH             one-cycle strobe per capture
//   overrun      out  NUM_CH             sticky: unconsumed data overwritten
// Revision : 1.0  initial release
// ============================================================================
module data_sync_mc #(
  parameter int NUM_STAGES  = 2,  // synchroniser depth, 2..4
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = 0   // 0: rising-edge event, 1: any-edge event
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic                        overrun_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           overrun
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0] sync_q,  sync_d;
    logic                  sprev_q, sprev_d;
    logic [BUS_WIDTH-1:0]  data_q,  data_d;
    logic                  valid_q, valid_d;
    logic                  pulse_q, pulse_d;
    logic                  ovr_q,   ovr_d;

    logic                  sen;
    logic                  evt;
    logic                  accept;

    // The last synchroniser stage is the first signal that is safe to use
    // in the CLK domain.
    assign sen = sync_q[NUM_STAGES-1];

    if (TOGGLE_MODE != 0) begin : g_toggle
      // Either enable transition marks a new word.
      assign evt = sen ^ sprev_q;
    end else begin : g_level
      // Only the rising edge counts, so a held-high enable yields one event.
      assign evt = sen & ~sprev_q;
    end

    // A consumer handshake only means something while a word is pending.
    assign accept = valid_q & sync_ready[c];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
      sync_d  = {sync_q[NUM_STAGES-2:0], bus_enable[c]};
      sprev_d = sen;

      // The source holds its data stable around the enable transition.
      // That makes the raw bus safe to sample during the event cycle.
      data_d  = data_q;
      if (evt) begin
        data_d = Unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
      end

      pulse_d = evt;

      // A new event keeps valid high even when the old word is being
      // accepted in the same cycle. The new word simply replaces it.
      valid_d = valid_q;
      if (evt) begin
        valid_d = 1'b1;
      end else if (accept) begin
        valid_d = 1'b0;
      end

      // Overwriting a pending, unaccepted word sets the flag. A set in the
      // same cycle as a clear takes priority over the clear.
      ovr_d = ovr_q;
      if (evt && valid_q && !sync_ready[c]) begin
        ovr_d = 1'b1;
      end else if (overrun_clr) begin
        ovr_d = 1'b0;
      end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        sync_q  <= '0;
        sprev_q <= 1'b0;
        data_q  <= '0;
        valid_q <= 1'b0;
        pulse_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        sprev_q <= sprev_d;
        data_q  <= data_d;
        valid_q <= valid_d;
        pulse_q <= pulse_d;
        ovr_q   <= ovr_d;
      end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sync_bus[c*BUS_WIDTH +: BUS_WIDTH] = data_q;
    assign sync_valid[c]                      = valid_q;
    assign enable_pulse[c]                    = pulse_q;
    assign overrun[c]                         = ovr_q;

  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_data_sync_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_sync_mc
// Purpose  : Directed self-checking bench for data_sync_mc. It uses one
//            level-mode instance and one toggle-mode instance. Both use the
//            default depth, width and channel count.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_sync_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] Unsync_bus;
  logic [1:0]  bus_enable;
  logic [1:0]  sync_ready;
  logic        overrun_clr;
  logic [15:0] sync_bus;
  logic [1:0]  sync_valid;
  logic [1:0]  enable_pulse;
  logic [1:0]  overrun;

  logic [15:0] t_unsync_bus;
  logic [1:0]  t_bus_enable;
  logic [1:0]  t_sync_ready;
  logic [15:0] t_sync_bus;
  logic [1:0]  t_sync_valid;
  logic [1:0]  t_enable_pulse;
  logic [1:0]  t_overrun;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(2), .TOGGLE_MODE(0)) u_lvl (
    .CLK(CLK), .RST(RST), .Unsync_bus(Unsync_bus), .bus_enable(bus_enable),
    .sync_ready(sync_ready), .overrun_clr(overrun_clr), .sync_bus(sync_bus),
    .sync_valid(sync_valid), .enable_pulse(enable_pulse), .overrun(overrun)
  );

  data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(2), .TOGGLE_MODE(1)) u_tog (
    .CLK(CLK), .RST(RST), .Unsync_bus(t_unsync_bus), .bus_enable(t_bus_enable),
    .sync_ready(t_sync_ready), .overrun_clr(overrun_clr), .sync_bus(t_sync_bus),
    .sync_valid(t_sync_valid), .enable_pulse(t_enable_pulse), .overrun(t_overrun)
  );

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sync_bus !== 16'h0) begin errors++; $display("FAIL reset_bus: got %h expected %h", sync_bus, 16'h0); end
    checks++; if ({sync_valid, enable_pulse, overrun} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected %b", {sync_valid, enable_pulse, overrun}, 6'b0); end
    checks++; if ({t_sync_bus, t_sync_valid, t_enable_pulse, t_overrun} !== 22'h0) begin errors++; $display("FAIL reset_tog: got %h expected %h", {t_sync_bus, t_sync_valid, t_enable_pulse, t_overrun}, 22'h0); end
    tick(); tick();
    RST = 1'b1;
    tick(); tick();
    checks++; if ({sync_bus, sync_valid, enable_pulse, overrun} !== 22'h0) begin errors++; $display("FAIL reset_release: got %h expected %h", {sync_bus, sync_valid, enable_pulse, overrun}, 22'h0); end
  endtask

  task automatic test_capture();
    Unsync_bus = 16'h5AA5;
    bus_enable = 2'b01;
    tick();
    checks++; if (sync_valid !== 2'b00) begin errors++; $display("FAIL cap_edge1_valid: got %b expected %b", sync_valid, 2'b00); end
    tick();
    checks++; if (enable_pulse !== 2'b00) begin errors++; $display("FAIL cap_edge2_pulse: got %b expected %b", enable_pulse, 2'b00); end
    tick();
    checks++; if (sync_bus !== 16'h00A5) begin errors++; $display("FAIL cap_bus: got %h expected %h", sync_bus, 16'h00A5); end
    checks++; if (sync_valid !== 2'b01) begin errors++; $display("FAIL cap_valid: got %b expected %b", sync_valid, 2'b01); end
    checks++; if (enable_pulse !== 2'b01) begin errors++; $display("FAIL cap_pulse: got %b expected %b", enable_pulse, 2'b01); end
    tick();
    checks++; if (enable_pulse !== 2'b00) begin errors++; $display("FAIL cap_pulse_end: got %b expected %b", enable_pulse, 2'b00); end
    checks++; if (sync_valid !== 2'b01) begin errors++; $display("FAIL cap_valid_hold: got %b expected %b", sync_valid, 2'b01); end
    sync_ready = 2'b01;
    tick();
    checks++; if (sync_valid !== 2'b00) begin errors++; $display("FAIL cap_valid_clear: got %b expected %b", sync_valid, 2'b00); end
    sync_ready = 2'b00;
    bus_enable = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_held_high();
    int pulses = 0;
    Unsync_bus = 16'h003C;
    sync_ready = 2'b01;
    bus_enable = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (enable_pulse[0]) pulses++;
      checks++; if (enable_pulse[0] !== (i == 3)) begin errors++; $display("FAIL held_pulse_%0d: got %b expected %b", i, enable_pulse[0], (i == 3)); end
      checks++; if (sync_valid[0] !== (i == 3)) begin errors++; $display("FAIL held_valid_%0d: got %b expected %b", i, sync_valid[0], (i == 3)); end
      if (i == 10) bus_enable = 2'b00;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_pulse_count: got %0d expected %0d", pulses, 1); end
    checks++; if (sync_bus[7:0] !== 8'h3C) begin errors++; $display("FAIL held_bus: got %h expected %h", sync_bus[7:0], 8'h3C); end
    sync_ready = 2'b00;
  endtask

  task automatic test_overrun();
    Unsync_bus = 16'h0033;
    bus_enable = 2'b01;
    tick(); tick(); tick();
    checks++; if (sync_bus[7:0] !== 8'h33) begin errors++; $display("FAIL ovr_first_bus: got %h expected %h", sync_bus[7:0], 8'h33); end
    bus_enable = 2'b00;
    tick(); tick(); tick();
    Unsync_bus = 16'h0044;
    bus_enable = 2'b01;
    tick(); tick();
    checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL ovr_before: got %b expected %b", overrun, 2'b00); end
    tick();
    checks++; if (sync_bus[7:0] !== 8'h44) begin errors++; $display("FAIL ovr_bus: got %h expected %h", sync_bus[7:0], 8'h44); end
    checks++; if (sync_valid !== 2'b01) begin errors++; $display("FAIL ovr_valid: got %b expected %b", sync_valid, 2'b01); end
    checks++; if (overrun !== 2'b01) begin errors++; $display("FAIL ovr_set: got %b expected %b", overrun, 2'b01); end
    overrun_clr = 1'b1;
    tick();
    checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL ovr_clear: got %b expected %b", overrun, 2'b00); end
    overrun_clr = 1'b0;
    bus_enable = 2'b00;
    tick(); tick(); tick();
    // Clear held across the overwriting event: the set must take priority.
    Unsync_bus = 16'h0055;
    bus_enable = 2'b01;
    overrun_clr = 1'b1;
    tick(); tick(); tick();
    checks++; if (overrun !== 2'b01) begin errors++; $display("FAIL ovr_set_wins: got %b expected %b", overrun, 2'b01); end
    checks++; if (sync_bus[7:0] !== 8'h55) begin errors++; $display("FAIL ovr_set_wins_bus: got %h expected %h", sync_bus[7:0], 8'h55); end
    tick();
    checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL ovr_clear_after: got %b expected %b", overrun, 2'b00); end
    overrun_clr = 1'b0;
    sync_ready = 2'b01;
    tick();
    checks++; if (sync_valid !== 2'b00) begin errors++; $display("FAIL ovr_drain: got %b expected %b", sync_valid, 2'b00); end
    sync_ready = 2'b00;
    bus_enable = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_event_accept();
    Unsync_bus = 16'h0066;
    bus_enable = 2'b01;
    tick(); tick(); tick();
    bus_enable = 2'b00;
    tick(); tick(); tick();
    checks++; if (sync_valid !== 2'b01) begin errors++; $display("FAIL ea_pending: got %b expected %b", sync_valid, 2'b01); end
    Unsync_bus = 16'h0077;
    bus_enable = 2'b01;
    tick(); tick();
    sync_ready = 2'b01;  // accept lands in the same cycle as the event
    tick();
    checks++; if (sync_bus[7:0] !== 8'h77) begin errors++; $display("FAIL ea_bus: got %h expected %h", sync_bus[7:0], 8'h77); end
    checks++; if (sync_valid !== 2'b01) begin errors++; $display("FAIL ea_valid: got %b expected %b", sync_valid, 2'b01); end
    checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL ea_overrun: got %b expected %b", overrun, 2'b00); end
    tick();
    checks++; if (sync_valid !== 2'b00) begin errors++; $display("FAIL ea_drain: got %b expected %b", sync_valid, 2'b00); end
    sync_ready = 2'b00;
    bus_enable = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_toggle();
    int pulses = 0;
    logic [7:0] exp_bus;
    t_sync_ready = 2'b01;
    t_unsync_bus = 16'h0011;
    t_bus_enable = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (t_enable_pulse[0]) pulses++;
      exp_bus = (i < 3) ? 8'h00 : (i < 7) ? 8'h11 : 8'h22;
      checks++; if (t_enable_pulse[0] !== (i == 3 || i == 7)) begin errors++; $display("FAIL tog_pulse_%0d: got %b expected %b", i, t_enable_pulse[0], (i == 3 || i == 7)); end
      checks++; if (t_sync_bus[7:0] !== exp_bus) begin errors++; $display("FAIL tog_bus_%0d: got %h expected %h", i, t_sync_bus[7:0], exp_bus); end
      if (i == 4) begin
        t_unsync_bus = 16'h0022;
        t_bus_enable = 2'b00;
      end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL tog_pulse_count: got %0d expected %0d", pulses, 2); end
    t_sync_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    Unsync_bus = 16'h0099;
    bus_enable = 2'b01;
    tick(); tick();
    #2 RST = 1'b0;
    #1;
    checks++; if (sync_bus !== 16'h0) begin errors++; $display("FAIL rst_mid_bus: got %h expected %h", sync_bus, 16'h0); end
    checks++; if ({sync_valid, enable_pulse, overrun} !== 6'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected %b", {sync_valid, enable_pulse, overrun}, 6'b0); end
    checks++; if (t_sync_bus !== 16'h0) begin errors++; $display("FAIL rst_mid_tog_bus: got %h expected %h", t_sync_bus, 16'h0); end
    bus_enable = 2'b00;
    tick(); tick();
    RST = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (enable_pulse != 2'b00) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_pulse: got %0d expected %0d", pulses, 0); end
    checks++; if ({sync_bus, sync_valid} !== 18'h0) begin errors++; $display("FAIL rst_mid_quiet: got %h expected %h", {sync_bus, sync_valid}, 18'h0); end
    // Enable already high when reset releases: capture after the chain fills.
    RST = 1'b0;
    Unsync_bus = 16'h00C3;
    bus_enable = 2'b01;
    tick();
    RST = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (enable_pulse[0] !== (i == 3)) begin errors++; $display("FAIL rst_rel_pulse_%0d: got %b expected %b", i, enable_pulse[0], (i == 3)); end
      checks++; if (sync_bus[7:0] !== ((i == 3) ? 8'hC3 : 8'h00)) begin errors++; $display("FAIL rst_rel_bus_%0d: got %h expected %h", i, sync_bus[7:0], ((i == 3) ? 8'hC3 : 8'h00)); end
    end
  endtask

  initial begin
    RST          = 1'b0;
    Unsync_bus   = 16'h0;
    bus_enable   = 2'b00;
    sync_ready   = 2'b00;
    overrun_clr  = 1'b0;
    t_unsync_bus = 16'h0;
    t_bus_enable = 2'b00;
    t_sync_ready = 2'b00;

    test_reset();
    test_capture();
    test_held_high();
    test_overrun();
    test_event_accept();
    test_toggle();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
